// File: rtl/ervp_trigger_event_ctrl_if.sv
// Purpose: configuration, trigger and status bundle for the trigger event controller.
// Latency: wires only; no storage.
// Backpressure: none; every field is a level or a single-cycle strobe.
interface ervp_trigger_event_ctrl_if #(
    parameter int BW_COUNT   = 16,
    parameter int BW_HOLDOFF = 16
);
    logic                  enable;
    logic                  mode_periodic;
    logic [BW_COUNT-1:0]   target_count;
    logic [BW_HOLDOFF-1:0] holdoff_cycles;
    logic                  sw_clear;
    logic                  triggered;
    logic                  checker_clear;
    logic                  event_pulse;
    logic                  irq;
    logic [BW_COUNT-1:0]   event_count;
    logic [1:0]            status;

    // Side that configures the block and observes its results.
    modport master (
        output enable, mode_periodic, target_count, holdoff_cycles, sw_clear, triggered,
        input  checker_clear, event_pulse, irq, event_count, status
    );

    // The controller itself.
    modport slave (
        input  enable, mode_periodic, target_count, holdoff_cycles, sw_clear, triggered,
        output checker_clear, event_pulse, irq, event_count, status
    );
endinterface

// File: rtl/ervp_trigger_event_ctrl.sv
// Purpose: counts accepted trigger matches and raises an event (pulse, irq, counter) at target.
// Latency: event_pulse/irq/event_count update one cycle after the completing trigger; checker_clear is combinational.
// Backpressure: none; triggers outside ARMED are dropped and the upstream checker is held cleared.
module ervp_trigger_event_ctrl #(
    parameter int BW_COUNT   = 16,
    parameter int BW_HOLDOFF = 16
) (
    input  logic                     clk,
    input  logic                     rstnn,
    ervp_trigger_event_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [BW_COUNT:0]     TGT_ONE  = (BW_COUNT+1)'(1);
    localparam logic [BW_COUNT-1:0]   CNT_ONE  = BW_COUNT'(1);
    localparam logic [BW_HOLDOFF-1:0] HOLD_ONE = BW_HOLDOFF'(1);

    state_t                state_q;
    logic [BW_COUNT-1:0]   match_cnt_q;
    logic [BW_COUNT-1:0]   event_count_q;
    logic [BW_HOLDOFF-1:0] holdoff_cnt_q;
    logic                  irq_q;
    logic                  event_pulse_q;

    logic [BW_COUNT:0]     eff_target_d;
    logic [BW_COUNT:0]     match_plus1_d;
    logic                  target_hit_d;
    logic [BW_COUNT-1:0]   event_count_d;

    // Match arithmetic is one bit wider so a full counter plus one cannot wrap.
    always_comb begin
        eff_target_d  = (bus.target_count == '0) ? TGT_ONE : {1'b0, bus.target_count};
        match_plus1_d = {1'b0, match_cnt_q} + TGT_ONE;
        target_hit_d  = (match_plus1_d >= eff_target_d);
        event_count_d = (&event_count_q) ? event_count_q : event_count_q + CNT_ONE;
    end

    // Control FSM; priority is enable, then sw_clear, then triggered.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q       <= ST_IDLE;
            match_cnt_q   <= '0;
            holdoff_cnt_q <= '0;
            event_count_q <= '0;
            irq_q         <= 1'b0;
            event_pulse_q <= 1'b0;
        end else begin
            event_pulse_q <= 1'b0;
            if (!bus.enable) begin
                // Disabling parks the block but keeps irq and the event history.
                state_q     <= ST_IDLE;
                match_cnt_q <= '0;
            end else if (bus.sw_clear) begin
                state_q       <= ST_ARMED;
                match_cnt_q   <= '0;
                event_count_q <= '0;
                irq_q         <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (bus.triggered) begin
                            if (!target_hit_d) begin
                                match_cnt_q <= match_plus1_d[BW_COUNT-1:0];
                            end else begin
                                match_cnt_q   <= '0;
                                event_pulse_q <= 1'b1;
                                irq_q         <= 1'b1;
                                event_count_q <= event_count_d;
                                if (bus.mode_periodic) begin
                                    state_q       <= ST_HOLDOFF;
                                    holdoff_cnt_q <= bus.holdoff_cycles;
                                end else begin
                                    state_q <= ST_DONE;
                                end
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        // Counter reads holdoff_cycles..0, giving holdoff_cycles+1 cycles here.
                        if (holdoff_cnt_q == '0) begin
                            state_q <= ST_ARMED;
                        end else begin
                            holdoff_cnt_q <= holdoff_cnt_q - HOLD_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_DONE;
                    end
                endcase
            end
        end
    end

    // Upstream checker restarts after every accepted match and stays cleared outside ARMED.
    always_comb begin
        bus.checker_clear = (state_q != ST_ARMED) || bus.triggered;
    end

    assign bus.event_pulse = event_pulse_q;
    assign bus.irq         = irq_q;
    assign bus.event_count = event_count_q;
    assign bus.status      = state_q;

endmodule

// File: tb/tb_ervp_trigger_event_ctrl.sv
// Purpose: scoreboard bench for the trigger event controller against an abstract reference model.
// Latency: one expectation is queued per clock and checked at the following falling edge.
// Backpressure: not applicable; the monitor consumes one expectation per cycle.
module tb_ervp_trigger_event_ctrl;

    localparam int BWC = 2;
    localparam int BWH = 4;
    localparam int SAT = (1 << BWC) - 1;
    localparam int P_IDLE = 0, P_ARMED = 1, P_HOLD = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rstnn;
    always #5 clk = ~clk;

    ervp_trigger_event_ctrl_if #(.BW_COUNT(BWC), .BW_HOLDOFF(BWH)) bus ();

    ervp_trigger_event_ctrl #(.BW_COUNT(BWC), .BW_HOLDOFF(BWH)) dut (
        .clk   (clk),
        .rstnn (rstnn),
        .bus   (bus)
    );

    typedef struct {
        int status;
        int irq;
        int pulse;
        int evcnt;
        int cc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    bit cfg_en, cfg_per;
    int cfg_tgt, cfg_hold;

    // Reference model: phase name, unbounded hit and event tallies, holdoff cycles still to spend.
    int m_phase, m_hits, m_hold_left, m_events;
    bit m_irq, m_pulse;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_phase     = P_IDLE;
        m_hits      = 0;
        m_hold_left = 0;
        m_events    = 0;
        m_irq       = 1'b0;
        m_pulse     = 1'b0;
    endfunction

    // One clock edge of the reference behaviour, from the inputs present at the edge.
    function automatic void model_edge(bit en, bit per, int tgt, int hold, bit clr, bit trg);
        int need;
        need    = (tgt == 0) ? 1 : tgt;
        m_pulse = 1'b0;
        if (!en) begin
            m_phase = P_IDLE;
            m_hits  = 0;
        end else if (clr) begin
            m_phase  = P_ARMED;
            m_hits   = 0;
            m_events = 0;
            m_irq    = 1'b0;
        end else if (m_phase == P_IDLE) begin
            m_phase = P_ARMED;
        end else if (m_phase == P_ARMED) begin
            if (trg) begin
                m_hits++;
                if (m_hits >= need) begin
                    m_hits      = 0;
                    m_pulse     = 1'b1;
                    m_irq       = 1'b1;
                    m_events++;
                    m_hold_left = hold + 1;
                    m_phase     = per ? P_HOLD : P_DONE;
                end
            end
        end else if (m_phase == P_HOLD) begin
            m_hold_left--;
            if (m_hold_left == 0) m_phase = P_ARMED;
        end
    endfunction

    // Advance one clock, then present the next inputs and queue what the DUT must show.
    task automatic step(input bit rst_n_v, input bit clr, input bit trg);
        exp_t e;
        @(posedge clk);
        if (rstnn) model_edge(bus.enable, bus.mode_periodic, int'(bus.target_count),
                              int'(bus.holdoff_cycles), bus.sw_clear, bus.triggered);
        else       model_reset();
        #2;
        rstnn              = rst_n_v;
        bus.enable         = cfg_en;
        bus.mode_periodic  = cfg_per;
        bus.target_count   = BWC'(cfg_tgt);
        bus.holdoff_cycles = BWH'(cfg_hold);
        bus.sw_clear       = clr;
        bus.triggered      = trg;
        if (!rstnn) model_reset();
        e.status = m_phase;
        e.irq    = int'(m_irq);
        e.pulse  = int'(m_pulse);
        e.evcnt  = (m_events > SAT) ? SAT : m_events;
        e.cc     = ((m_phase != P_ARMED) || trg) ? 1 : 0;
        sb_q.push_back(e);
    endtask

    task automatic run(input int n, input bit clr, input bit trg);
        for (int i = 0; i < n; i++) step(1'b1, clr, trg);
    endtask

    task automatic set_cfg(input bit en, input bit per, input int tgt, input int hold);
        cfg_en   = en;
        cfg_per  = per;
        cfg_tgt  = tgt;
        cfg_hold = hold;
    endtask

    // Monitor: compare every output against the oldest pending expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("status",        int'(bus.status),        e.status);
                chk("irq",           int'(bus.irq),           e.irq);
                chk("event_pulse",   int'(bus.event_pulse),   e.pulse);
                chk("event_count",   int'(bus.event_count),   e.evcnt);
                chk("checker_clear", int'(bus.checker_clear), e.cc);
            end
        end
    end

    initial begin : driver
        rstnn              = 1'b0;
        bus.enable         = 1'b0;
        bus.mode_periodic  = 1'b0;
        bus.target_count   = '0;
        bus.holdoff_cycles = '0;
        bus.sw_clear       = 1'b0;
        bus.triggered      = 1'b0;
        set_cfg(1'b0, 1'b0, 0, 0);
        model_reset();

        // Reset values, then release with enable high.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        set_cfg(1'b1, 1'b0, 1, 0);
        run(2, 1'b0, 1'b0);

        // One-shot with target 1; extra triggers in DONE do nothing; sw_clear re-arms.
        step(1'b1, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);
        run(3, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);

        // Periodic, target 3, holdoff 4; triggers during holdoff are dropped.
        set_cfg(1'b1, 1'b1, 3, 4);
        run(3, 1'b0, 1'b1);
        run(6, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);
        run(3, 1'b0, 1'b1);
        run(7, 1'b0, 1'b0);

        // Target 0 and holdoff 0: every accepted trigger is an event; count saturates.
        step(1'b1, 1'b1, 1'b0);
        set_cfg(1'b1, 1'b1, 0, 0);
        run(14, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);

        // sw_clear coinciding with the completing trigger wins.
        set_cfg(1'b1, 1'b1, 3, 0);
        step(1'b1, 1'b1, 1'b0);
        run(2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        run(2, 1'b0, 1'b0);

        // Drop enable with two matches and irq pending, then re-enable.
        run(3, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);
        run(2, 1'b0, 1'b1);
        set_cfg(1'b0, 1'b1, 3, 0);
        run(2, 1'b0, 1'b0);
        set_cfg(1'b1, 1'b1, 3, 0);
        run(2, 1'b0, 1'b0);
        run(4, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);

        // Reset in the middle of HOLDOFF, then release with enable high.
        set_cfg(1'b1, 1'b1, 2, 9);
        run(2, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);

        // Randomized traffic with occasional config changes, clears, disables and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_cfg($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0,
                 1'($urandom_range(0, 1)));
        end

        run(1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
